keypad_scanner: RTL

Matrix-keypad scanner for the 4x4 hex keypad on a Pmod header. It is the input-side counterpart of the strobed 7-segment driver. Instead of strobing anodes to drive out data, it strobes keypad columns and reads rows back to decode one debounced keypress. It runs on the 25 MHz system clock. Its output is a one-cycle `key_valid` strobe with a 4-bit hex code, consumed by the game FSMs and shown on the 8-digit display.

---
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and single-key decode; define KEYPAD_REPEAT_EN for auto-repeat
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       multi_key
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  // hex code of snapshot bit b = 4*col + row, packed at [4b+3:4b]
  localparam logic [63:0] CODE_MAP = 64'hDCBA_E963_F852_0741;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_MULTI} state_t;
  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} kind_t;

  logic [3:0]    r_row_s1, r_row_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;
  logic [15:0]   r_snap;
  kind_t         r_prev_kind;
  logic [3:0]    r_prev_idx;
  logic [SW-1:0] r_stable_cnt;
  state_t        r_state, w_state_nx;
  logic          r_key_valid, w_valid_nx;
  logic [3:0]    r_key_code, w_code_nx;
  logic          w_last, w_scan_done, w_same, w_stable;
  logic [15:0]   w_snap;
  logic [4:0]    w_pop;
  logic [3:0]    w_idx, w_code;
  kind_t         w_kind;
  logic [SW-1:0] w_cnt_nx;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RW-1:0] r_rep_cnt, w_rep_nx, w_rep_inc;
  assign w_rep_inc = r_rep_cnt + RW'(1);
`endif

  assign w_last      = r_dwell == DW'(SCAN_DIV - 1);
  assign w_scan_done = w_last && r_col_idx == 2'd3;
  // column 3's sample is folded in combinationally so the scan is judged on the cycle it completes
  assign w_snap      = {~r_row_s2, r_snap[11:0]};
  assign w_kind      = w_pop == 5'd0 ? K_NONE : w_pop == 5'd1 ? K_SINGLE : K_MULTI;
  assign w_code      = CODE_MAP[{w_idx, 2'b00} +: 4];
  assign w_same      = w_kind == r_prev_kind && (w_kind != K_SINGLE || w_idx == r_prev_idx);
  assign w_cnt_nx    = !w_same ? SW'(1) : r_stable_cnt == SW'(DEBOUNCE_SCANS) ? r_stable_cnt : r_stable_cnt + SW'(1);
  assign w_stable    = w_cnt_nx == SW'(DEBOUNCE_SCANS);

  assign col_n     = ~(4'b0001 << r_col_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_down  = r_state == S_PRESSED;
  assign multi_key = r_state == S_MULTI;

  // count pressed bits in the finished snapshot and remember the highest one
  always_comb begin
    w_pop = 5'd0;
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (w_snap[i]) begin
        w_pop = w_pop + 5'd1;
        w_idx = 4'(i);
      end
  end

  // row synchronizer, column dwell/step and per-column row sampling
  always_ff @(posedge clock)
    if (reset) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
      r_snap    <= '0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      r_dwell  <= w_last ? '0 : r_dwell + DW'(1);
      if (w_last) begin
        r_col_idx                   <= r_col_idx + 2'd1;
        r_snap[{r_col_idx, 2'b00} +: 4] <= ~r_row_s2;
      end
    end

  // track how many consecutive scans produced the same classification
  always_ff @(posedge clock)
    if (reset) begin
      r_prev_kind  <= K_NONE;
      r_prev_idx   <= 4'd0;
      r_stable_cnt <= '0;
    end else if (w_scan_done) begin
      r_prev_kind  <= w_kind;
      r_prev_idx   <= w_idx;
      r_stable_cnt <= w_cnt_nx;
    end

  // key FSM: acts only on a stable classification at the end of a scan
  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = 1'b0;
    w_code_nx  = r_key_code;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nx   = r_rep_cnt;
`endif
    if (w_scan_done && w_stable)
      case (r_state)
        S_IDLE: begin
          w_state_nx = w_kind == K_SINGLE ? S_PRESSED : w_kind == K_MULTI ? S_MULTI : S_IDLE;
          w_valid_nx = w_kind == K_SINGLE;
          w_code_nx  = w_kind == K_SINGLE ? w_code : r_key_code;
`ifdef KEYPAD_REPEAT_EN
          w_rep_nx   = '0;
`endif
        end
        S_PRESSED: begin
          w_state_nx = w_kind == K_NONE ? S_IDLE : w_kind == K_MULTI ? S_MULTI : S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
          if (w_kind != K_SINGLE)
            w_rep_nx = '0;
          else if (w_code == r_key_code) begin
            w_valid_nx = w_rep_inc == RW'(REPEAT_DELAY) || w_rep_inc == RW'(REPEAT_DELAY + REPEAT_RATE);
            w_rep_nx   = w_rep_inc == RW'(REPEAT_DELAY + REPEAT_RATE) ? RW'(REPEAT_DELAY) : w_rep_inc;
          end
`endif
        end
        S_MULTI: w_state_nx = w_kind == K_NONE ? S_IDLE : S_MULTI;
        default: w_state_nx = S_IDLE;
      endcase
  end

  // state and registered outputs
  always_ff @(posedge clock)
    if (reset) begin
      r_state     <= S_IDLE;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_key_valid <= w_valid_nx;
      r_key_code  <= w_code_nx;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_nx;
`endif
    end
endmodule
